// File: rtl/part_vector_tester.sv
// UART-driven part vector tester: receives PI vectors, applies them, captures POs and reports pass/fail or raw outputs.
// Commands are byte-serial; responses are paced by the tx_ready handshake.
module part_vector_tester #(
    parameter int NPIS    = 14,
    parameter int NPOS    = 11,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_rcv,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_ready,
    output logic [NPIS-1:0] part_pis_o,
    input  logic [NPOS-1:0] part_pos_i,
    output logic            busy,
    output logic [7:0]      leds
);

    localparam int PB = (NPIS + 7) / 8;
    localparam int OB = (NPOS + 7) / 8;
    localparam int TB = (OB > 3) ? OB : 3;
    localparam int PW = PB * 8;
    localparam int OW = OB * 8;
    localparam int TW = TB * 8;
    localparam logic [3:0]  PB_LAST  = 4'(PB - 1);
    localparam logic [3:0]  OB_LAST  = 4'(OB - 1);
    localparam logic [3:0]  OB_CNT   = 4'(OB);
    localparam logic [15:0] SET_LAST = 16'(SETTLE - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
    localparam bit          TO_EN    = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RX_PI, ST_RX_EXP, ST_RX_MASK, ST_SETTLE, ST_CAPTURE, ST_TX
    } state_t;

    typedef enum logic [1:0] {TX_SEND, TX_WAIT_LOW, TX_WAIT_HIGH} tx_ph_t;

    state_t      state_q;
    tx_ph_t      tx_ph_q;
    logic        is_v_q;
    logic [3:0]  byte_cnt_q;
    logic [15:0] set_cnt_q;
    logic [31:0] to_cnt_q;
    logic [PW-1:0] shadow_q;
    logic [OW-1:0] exp_q;
    logic [OW-1:0] mask_q;
    logic [TW-1:0] tx_buf_q;
    logic [3:0]  tx_left_q;
    logic [15:0] err_cnt_q;
    logic [15:0] vec_cnt_q;
    logic        tout_q;
    logic        ovr_q;

    logic [PW-1:0] shadow_d;
    logic [OW-1:0] exp_d;
    logic [OW-1:0] mask_d;
    logic          po_fail;
    logic          to_expired;

    // Bytes arrive MSB first, so each new byte shifts in at the bottom.
    assign shadow_d   = (shadow_q << 8) | PW'(rx_data);
    assign exp_d      = (exp_q << 8) | OW'(rx_data);
    assign mask_d     = (mask_q << 8) | OW'(rx_data);
    assign po_fail    = |((part_pos_i ^ exp_q[NPOS-1:0]) & mask_q[NPOS-1:0]);
    assign to_expired = TO_EN && !rx_rcv && (to_cnt_q == TO_LAST);

    assign busy = (state_q != ST_IDLE);
    assign leds = vec_cnt_q[7:0];

    // Response bytes are left-justified so the shifter always sends the top byte.
    function automatic logic [TW-1:0] msg1(input logic [7:0] b);
        return TW'(b) << (TW - 8);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_ph_q    <= TX_SEND;
            is_v_q     <= 1'b0;
            byte_cnt_q <= '0;
            set_cnt_q  <= '0;
            to_cnt_q   <= '0;
            shadow_q   <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            tx_buf_q   <= '0;
            tx_left_q  <= '0;
            err_cnt_q  <= '0;
            vec_cnt_q  <= '0;
            tout_q     <= 1'b0;
            ovr_q      <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            part_pis_o <= '0;
        end else begin
            tx_start <= 1'b0;
            if (rx_rcv && (state_q == ST_SETTLE || state_q == ST_CAPTURE || state_q == ST_TX))
                ovr_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (rx_rcv) begin
                        byte_cnt_q <= '0;
                        to_cnt_q   <= '0;
                        tx_ph_q    <= TX_SEND;
                        case (rx_data)
                            8'h56: begin is_v_q <= 1'b1; state_q <= ST_RX_PI; end
                            8'h43: begin is_v_q <= 1'b0; state_q <= ST_RX_PI; end
                            8'h53: begin
                                tx_buf_q  <= TW'({6'b0, tout_q, ovr_q, err_cnt_q}) << (TW - 24);
                                tx_left_q <= 4'd3;
                                state_q   <= ST_TX;
                            end
                            8'h52: begin
                                err_cnt_q <= '0;
                                vec_cnt_q <= '0;
                                tout_q    <= 1'b0;
                                ovr_q     <= 1'b0;
                                tx_buf_q  <= msg1(8'h4B);
                                tx_left_q <= 4'd1;
                                state_q   <= ST_TX;
                            end
                            default: begin
                                tx_buf_q  <= msg1(8'h3F);
                                tx_left_q <= 4'd1;
                                state_q   <= ST_TX;
                            end
                        endcase
                    end
                end

                ST_RX_PI, ST_RX_EXP, ST_RX_MASK: begin
                    if (rx_rcv) begin
                        to_cnt_q <= '0;
                        case (state_q)
                            ST_RX_PI: begin
                                shadow_q <= shadow_d;
                                if (byte_cnt_q == PB_LAST) begin
                                    byte_cnt_q <= '0;
                                    if (is_v_q) begin
                                        state_q <= ST_RX_EXP;
                                    end else begin
                                        part_pis_o <= shadow_d[NPIS-1:0];
                                        vec_cnt_q  <= vec_cnt_q + 16'd1;
                                        set_cnt_q  <= '0;
                                        state_q    <= ST_SETTLE;
                                    end
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 4'd1;
                                end
                            end
                            ST_RX_EXP: begin
                                exp_q <= exp_d;
                                if (byte_cnt_q == OB_LAST) begin
                                    byte_cnt_q <= '0;
                                    state_q    <= ST_RX_MASK;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 4'd1;
                                end
                            end
                            default: begin
                                mask_q <= mask_d;
                                if (byte_cnt_q == OB_LAST) begin
                                    // The vector is applied only once the whole command is in hand.
                                    byte_cnt_q <= '0;
                                    part_pis_o <= shadow_q[NPIS-1:0];
                                    vec_cnt_q  <= vec_cnt_q + 16'd1;
                                    set_cnt_q  <= '0;
                                    state_q    <= ST_SETTLE;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 4'd1;
                                end
                            end
                        endcase
                    end else if (to_expired) begin
                        tout_q    <= 1'b1;
                        tx_buf_q  <= msg1(8'h21);
                        tx_left_q <= 4'd1;
                        tx_ph_q   <= TX_SEND;
                        state_q   <= ST_TX;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                end

                ST_SETTLE: begin
                    if (set_cnt_q == SET_LAST) begin
                        set_cnt_q <= '0;
                        state_q   <= ST_CAPTURE;
                    end else begin
                        set_cnt_q <= set_cnt_q + 16'd1;
                    end
                end

                ST_CAPTURE: begin
                    tx_ph_q <= TX_SEND;
                    state_q <= ST_TX;
                    if (is_v_q) begin
                        tx_left_q <= 4'd1;
                        if (po_fail) begin
                            tx_buf_q <= msg1(8'h46);
                            if (err_cnt_q != 16'hFFFF)
                                err_cnt_q <= err_cnt_q + 16'd1;
                        end else begin
                            tx_buf_q <= msg1(8'h50);
                        end
                    end else begin
                        tx_buf_q  <= TW'(part_pos_i) << (TW - OW);
                        tx_left_q <= OB_CNT;
                    end
                end

                ST_TX: begin
                    case (tx_ph_q)
                        TX_SEND: begin
                            if (tx_ready) begin
                                tx_start  <= 1'b1;
                                tx_data   <= tx_buf_q[TW-1 -: 8];
                                tx_buf_q  <= tx_buf_q << 8;
                                tx_left_q <= tx_left_q - 4'd1;
                                if (tx_left_q == 4'd1)
                                    state_q <= ST_IDLE;
                                else
                                    tx_ph_q <= TX_WAIT_LOW;
                            end
                        end
                        TX_WAIT_LOW:  if (!tx_ready) tx_ph_q <= TX_WAIT_HIGH;
                        default:      if (tx_ready)  tx_ph_q <= TX_SEND;
                    endcase
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_part_vector_tester.sv
// Randomized self-checking bench for part_vector_tester against a command-level reference model.
module tb_part_vector_tester;
    localparam int NPIS    = 14;
    localparam int NPOS    = 11;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 60;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_rcv;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_ready;
    logic [NPIS-1:0] part_pis_o;
    logic [NPOS-1:0] part_pos_i;
    logic            busy;
    logic [7:0]      leds;

    int checks   = 0;
    int failures = 0;
    logic [7:0] got[$];
    int rd_idx    = 0;
    int proto_err = 0;

    logic [15:0]     m_err;
    logic [15:0]     m_vec;
    logic            m_tout;
    logic            m_ovr;
    logic [NPIS-1:0] m_pis;

    part_vector_tester #(.NPIS(NPIS), .NPOS(NPOS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rcv(rx_rcv),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
        .part_pis_o(part_pis_o), .part_pos_i(part_pos_i), .busy(busy), .leds(leds)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: records bytes and goes busy for a random time.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (tx_ready !== 1'b1) proto_err++;
                got.push_back(tx_data);
                tx_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_rcv  = 1'b1;
        @(negedge clk);
        rx_rcv  = 1'b0;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int cyc = 0;
        while ((got.size() < rd_idx + n || busy === 1'b1) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (12) @(negedge clk);
        ok = (got.size() == rd_idx + n);
    endtask

    task automatic model_reset;
        m_err = '0; m_vec = '0; m_tout = 1'b0; m_ovr = 1'b0; m_pis = '0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (part_pis_o !== '0) begin failures++; $display("FAIL reset_pis got=%h exp=0", part_pis_o); end
        checks++; if (busy !== 1'b0 || leds !== 8'h00) begin failures++; $display("FAIL reset_busy_leds got=%b/%h exp=0/00", busy, leds); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vector(input logic [15:0] pi, input logic [15:0] ex, input logic [15:0] mk,
                              input logic [10:0] po, input int gap, input string name);
        logic [7:0] eb;
        logic [NPIS-1:0] pis_before;
        bit ok;
        part_pos_i = po;
        pis_before = m_pis;
        m_pis = pi[NPIS-1:0];
        m_vec = m_vec + 16'd1;
        if (((po ^ ex[10:0]) & mk[10:0]) != 0) begin
            eb = 8'h46;
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end else begin
            eb = 8'h50;
        end
        send_byte(8'h56, gap); send_byte(pi[15:8], gap); send_byte(pi[7:0], gap); send_byte(ex[15:8], gap);
        checks++;
        if (part_pis_o !== pis_before) begin failures++; $display("FAIL %s_partial pis got=%h exp=%h", name, part_pis_o, pis_before); end
        send_byte(ex[7:0], gap); send_byte(mk[15:8], gap); send_byte(mk[7:0], gap);
        wait_tx(1, ok);
        checks++;
        if (!ok || got[rd_idx] !== eb) begin
            failures++;
            $display("FAIL %s_resp bytes=%0d first=%h exp=1x%h", name, got.size() - rd_idx,
                     (got.size() > rd_idx) ? got[rd_idx] : 8'h00, eb);
        end
        rd_idx = got.size();
        checks++; if (part_pis_o !== m_pis) begin failures++; $display("FAIL %s_pis got=%h exp=%h", name, part_pis_o, m_pis); end
        checks++; if (leds !== m_vec[7:0]) begin failures++; $display("FAIL %s_leds got=%h exp=%h", name, leds, m_vec[7:0]); end
    endtask

    task automatic run_capture(input logic [15:0] pi, input logic [10:0] po, input int gap, input string name);
        logic [7:0] eb[2];
        bit ok;
        part_pos_i = po;
        m_pis = pi[NPIS-1:0];
        m_vec = m_vec + 16'd1;
        eb[0] = {5'b0, po[10:8]};
        eb[1] = po[7:0];
        send_byte(8'h43, gap); send_byte(pi[15:8], gap); send_byte(pi[7:0], gap);
        wait_tx(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_count got=%0d exp=2", name, got.size() - rd_idx); end
        else for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[rd_idx + i] !== eb[i]) begin failures++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, got[rd_idx + i], eb[i]); end
        end
        rd_idx = got.size();
        checks++; if (part_pis_o !== m_pis) begin failures++; $display("FAIL %s_pis got=%h exp=%h", name, part_pis_o, m_pis); end
        checks++; if (leds !== m_vec[7:0]) begin failures++; $display("FAIL %s_leds got=%h exp=%h", name, leds, m_vec[7:0]); end
    endtask

    task automatic test_status(input string name);
        logic [7:0] eb[3];
        bit ok;
        eb[0] = {6'b0, m_tout, m_ovr};
        eb[1] = m_err[15:8];
        eb[2] = m_err[7:0];
        send_byte(8'h53, 0);
        wait_tx(3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_count got=%0d exp=3", name, got.size() - rd_idx); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[rd_idx + i] !== eb[i]) begin failures++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, got[rd_idx + i], eb[i]); end
        end
        rd_idx = got.size();
    endtask

    task automatic test_clear;
        bit ok;
        send_byte(8'h52, 0);
        model_reset_counters();
        wait_tx(1, ok);
        checks++;
        if (!ok || got[rd_idx] !== 8'h4B) begin
            failures++;
            $display("FAIL clear_resp bytes=%0d first=%h exp=4b", got.size() - rd_idx, (got.size() > rd_idx) ? got[rd_idx] : 8'h00);
        end
        rd_idx = got.size();
        checks++; if (leds !== 8'h00) begin failures++; $display("FAIL clear_leds got=%h exp=00", leds); end
    endtask

    task automatic model_reset_counters;
        m_err = '0; m_vec = '0; m_tout = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic test_directed;
        run_vector(16'h1234, 16'h0567, 16'h07FF, 11'h567, 0, "v_pass");
        checks++; if (part_pis_o !== 14'h1234 || leds !== 8'h01) begin failures++; $display("FAIL v_example pis/leds got=%h/%h exp=1234/01", part_pis_o, leds); end
        run_vector(16'h1234, 16'h0567, 16'h07FF, 11'h566, 1, "v_fail");
        test_status("status_err1");
        run_vector(16'h1234, 16'h0567, 16'h07FE, 11'h566, 2, "v_masked");
        test_status("status_err_kept");
        run_capture(16'hFFFF, 11'h7FF, 0, "cap_ones");
        checks++; if (part_pis_o !== 14'h3FFF) begin failures++; $display("FAIL cap_ones_example got=%h exp=3fff", part_pis_o); end
    endtask

    task automatic test_random;
        logic [15:0] pi, ex, mk;
        logic [10:0] po;
        for (int i = 0; i < 25; i++) begin
            pi = 16'($urandom);
            po = 11'($urandom);
            mk = 16'($urandom);
            ex = {5'($urandom), po};
            if ($urandom_range(0, 1) == 1) ex[$urandom_range(0, 10)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) run_capture(pi, po, $urandom_range(0, 3), "rnd_cap");
            else run_vector(pi, ex, mk, po, $urandom_range(0, 3), "rnd_vec");
        end
    endtask

    task automatic test_timeout_edge;
        run_vector(16'h2A5C, 16'h0123, 16'h07FF, 11'h123, TIMEOUT - 1, "to_edge");
        checks++; if (m_tout !== 1'b0 || got.size() != rd_idx) begin failures++; $display("FAIL to_edge_extra bytes=%0d exp=0", got.size() - rd_idx); end
    endtask

    task automatic test_timeout;
        bit ok;
        logic [NPIS-1:0] pis_before;
        logic [7:0] lead_before;
        pis_before = part_pis_o;
        lead_before = leds;
        send_byte(8'h56, 0); send_byte(8'h12, 0);
        m_tout = 1'b1;
        wait_tx(1, ok);
        checks++;
        if (!ok || got[rd_idx] !== 8'h21) begin
            failures++;
            $display("FAIL timeout_pi_resp bytes=%0d first=%h exp=21", got.size() - rd_idx, (got.size() > rd_idx) ? got[rd_idx] : 8'h00);
        end
        rd_idx = got.size();
        checks++; if (part_pis_o !== pis_before || leds !== lead_before) begin failures++; $display("FAIL timeout_pi_pis got=%h exp=%h", part_pis_o, pis_before); end
        send_byte(8'h56, 0); send_byte(8'h3A, 0); send_byte(8'hBC, 0);
        send_byte(8'h00, 0); send_byte(8'h11, 0); send_byte(8'h07, 0);
        wait_tx(1, ok);
        checks++;
        if (!ok || got[rd_idx] !== 8'h21) begin
            failures++;
            $display("FAIL timeout_mask_resp bytes=%0d first=%h exp=21", got.size() - rd_idx, (got.size() > rd_idx) ? got[rd_idx] : 8'h00);
        end
        rd_idx = got.size();
        checks++; if (part_pis_o !== pis_before) begin failures++; $display("FAIL timeout_mask_pis got=%h exp=%h", part_pis_o, pis_before); end
    endtask

    task automatic test_unknown;
        logic [7:0] b;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            b = 8'h58;
            if (i > 0) begin
                b = 8'($urandom);
                while (b == 8'h56 || b == 8'h43 || b == 8'h53 || b == 8'h52) b = 8'($urandom);
            end
            send_byte(b, 0);
            wait_tx(1, ok);
            checks++;
            if (!ok || got[rd_idx] !== 8'h3F) begin
                failures++;
                $display("FAIL unknown_%h bytes=%0d first=%h exp=3f", b, got.size() - rd_idx, (got.size() > rd_idx) ? got[rd_idx] : 8'h00);
            end
            rd_idx = got.size();
        end
    endtask

    task automatic test_overrun;
        logic [7:0] eb[3];
        bit ok;
        eb[0] = {6'b0, m_tout, m_ovr};
        eb[1] = m_err[15:8];
        eb[2] = m_err[7:0];
        send_byte(8'h53, 0);
        send_byte(8'h56, 0);
        m_ovr = 1'b1;
        wait_tx(3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL overrun_count got=%0d exp=3", got.size() - rd_idx); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[rd_idx + i] !== eb[i]) begin failures++; $display("FAIL overrun_byte%0d got=%h exp=%h", i, got[rd_idx + i], eb[i]); end
        end
        rd_idx = got.size();
        test_status("status_overrun");
    endtask

    task automatic test_reset_mid_tx;
        int cyc = 0;
        part_pos_i = 11'h7FF;
        send_byte(8'h43, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        while (got.size() < rd_idx + 1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (got.size() < rd_idx + 1) begin failures++; $display("FAIL midrst_first_byte got=%0d exp=1", got.size() - rd_idx); end
        rst = 1'b1;
        #1;
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_abort start/busy got=%b/%b exp=0/0", tx_start, busy); end
        checks++; if (part_pis_o !== '0 || leds !== 8'h00) begin failures++; $display("FAIL midrst_pis got=%h/%h exp=0/00", part_pis_o, leds); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd_idx = rd_idx + 1;
        repeat (20) @(negedge clk);
        checks++; if (got.size() != rd_idx) begin failures++; $display("FAIL midrst_stray bytes=%0d exp=0", got.size() - rd_idx); end
        rd_idx = got.size();
        test_status("status_after_rst");
    endtask

    task automatic test_protocol;
        checks++; if (proto_err != 0) begin failures++; $display("FAIL tx_handshake violations=%0d exp=0", proto_err); end
    endtask

    initial begin
        rst = 1'b1;
        rx_rcv = 1'b0;
        rx_data = 8'h00;
        part_pos_i = '0;
        model_reset();
        test_reset();
        test_status("status_reset");
        test_directed();
        test_random();
        test_timeout_edge();
        test_clear();
        test_timeout();
        test_status("status_timeout");
        test_clear();
        test_status("status_cleared");
        test_unknown();
        test_overrun();
        test_reset_mid_tx();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
